// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the scan sequencer and its mask lookup.
package scan_pkg;

  // Channel count and index width of the downstream 3-to-8 decoder.
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/scan_sequencer_mask_next_index.sv
// Combinational channel lookup over an 8-bit enable mask: lowest set bit,
// next set bit strictly above the current index, and a wrap flag when no
// higher bit exists. When wrapping, nxt falls back to the lowest set bit so
// a continuous scan can take it directly.
module mask_next_index
  import scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  nxt,
  output logic [SEL_W-1:0]  first,
  output logic              wrap
);

  logic [SEL_W-1:0] first_s;
  logic [SEL_W-1:0] higher_s;
  logic             found_s;

  // Scan from the top bit down so the last hit is the lowest qualifying bit.
  always_comb begin
    first_s  = 3'd0;
    higher_s = 3'd0;
    found_s  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      first_s  = mask[i] ? SEL_W'(i) : first_s;
      higher_s = (mask[i] && (SEL_W'(i) > cur)) ? SEL_W'(i) : higher_s;
      found_s  = found_s | (mask[i] && (SEL_W'(i) > cur));
    end
  end

  assign first = first_s;
  assign nxt   = found_s ? higher_s : first_s;
  assign wrap  = ~found_s;

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit channel index through the enabled channels
// of a latched mask, holding each for dwell+1 cycles, in single-pass or
// continuous mode. sel drives the 3-to-8 decoder input; sel_valid
// qualifies the decoded one-hot.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int NUM_CH  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               slot_tick,
  output logic               busy,
  output logic               done
);

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic               sel_valid_q;
  logic               busy_q;
  logic               done_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [NUM_CH-1:0]  mask_l_q;
  logic [DWELL_W-1:0] dwell_l_q;
  logic               mode_l_q;

  logic [NUM_CH-1:0]  lkp_mask_s;
  logic [SEL_W-1:0]   lkp_nxt_s;
  logic [SEL_W-1:0]   lkp_first_s;
  logic               lkp_wrap_s;
  logic               slot_end_s;

  // One lookup serves both uses: in IDLE it sees the incoming mask (start
  // lookup), otherwise the latched mask (slot advance).
  assign lkp_mask_s = (state_q == IDLE) ? mask : mask_l_q;

  mask_next_index u_lookup (
    .mask  (lkp_mask_s),
    .cur   (sel_q),
    .nxt   (lkp_nxt_s),
    .first (lkp_first_s),
    .wrap  (lkp_wrap_s)
  );

  // End of the current slot; equality compare so the counter never overflows.
  assign slot_end_s = (cnt_q == dwell_l_q);

  // Control FSM with registered outputs; reset aborts any scan silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      mask_l_q    <= '0;
      dwell_l_q   <= '0;
      mode_l_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          // stop beats start; an empty mask goes straight to DONE.
          if (start && !stop) begin
            if (|mask) begin
              mask_l_q    <= mask;
              dwell_l_q   <= dwell;
              mode_l_q    <= mode;
              sel_q       <= lkp_first_s;
              cnt_q       <= '0;
              sel_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= SCAN;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            state_q <= IDLE;
          end
        end

        SCAN: begin
          if (stop) begin
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end else if (slot_end_s) begin
            cnt_q <= '0;
            if (!lkp_wrap_s || mode_l_q) begin
              // nxt already wraps to the lowest set bit in continuous mode.
              sel_q <= lkp_nxt_s;
            end else begin
              sel_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end else begin
            cnt_q <= cnt_q + DWELL_W'(1);
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q     <= IDLE;
          sel_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign slot_tick = (state_q == SCAN) && slot_end_s;

endmodule
